// File: rtl/sd_photo_loader.sv
// Streams raw RGB888 sectors from the SD read port, repacks them to RGB565 and
// writes them to SDRAM; one image per load_start, chosen by pic_sel.
module sd_photo_loader #(
  parameter logic [31:0] PIC0_SEC = 32'd8000,
  parameter logic [31:0] PIC1_SEC = 32'd16000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sdram_max_addr,
  input  logic [15:0] sd_sec_num,
  input  logic        load_start,
  input  logic        pic_sel,
  input  logic        sd_rd_busy,
  input  logic        sd_rd_val_en,
  input  logic [15:0] sd_rd_val_data,
  output logic        sd_rd_start_en,
  output logic [31:0] sd_rd_sec_addr,
  output logic        sdram_wr_en,
  output logic [15:0] sdram_wr_data,
  output logic        load_busy,
  output logic        load_done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t      state, state_nxt;
  logic [23:0] max_q, pix_cnt;
  logic [15:0] sec_num_q, sec_cnt, sec_inc;
  logic [31:0] base_q;
  logic [1:0]  phase;
  logic [15:0] held;
  logic        accept, sec_end;

  assign accept  = (state == IDLE) && load_start;
  assign sec_inc = sec_cnt + 16'd1;
  assign sec_end = (state == WAIT_LO) && !sd_rd_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero sector count still passes through REQ, but issues no request there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = REQ;
      REQ:     state_nxt = (sec_num_q == 16'd0) ? DONE : WAIT_HI;
      WAIT_HI: if (sd_rd_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!sd_rd_busy) state_nxt = (sec_inc == sec_num_q) ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sd_rd_start_en = (state == REQ) && (sec_num_q != 16'd0);
  assign load_busy      = (state != IDLE);
  assign load_done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q          <= '0;
      sec_num_q      <= '0;
      base_q         <= '0;
      sec_cnt        <= '0;
      sd_rd_sec_addr <= '0;
    end else if (accept) begin
      max_q     <= sdram_max_addr;
      sec_num_q <= sd_sec_num;
      base_q    <= pic_sel ? PIC1_SEC : PIC0_SEC;
      sec_cnt   <= '0;
      if (sd_sec_num != 16'd0) sd_rd_sec_addr <= pic_sel ? PIC1_SEC : PIC0_SEC;
    end else if (sec_end) begin
      sec_cnt <= sec_inc;
      if (sec_inc != sec_num_q) sd_rd_sec_addr <= base_q + {16'd0, sec_inc};
    end
  end

  // Three words carry two pixels; the phase runs continuously across sectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase         <= '0;
      held          <= '0;
      pix_cnt       <= '0;
      sdram_wr_en   <= 1'b0;
      sdram_wr_data <= '0;
    end else begin
      sdram_wr_en <= 1'b0;
      if (accept) begin
        phase   <= '0;
        pix_cnt <= '0;
      end else if ((state != IDLE) && sd_rd_val_en) begin
        case (phase)
          2'd0: begin
            held  <= sd_rd_val_data;
            phase <= 2'd1;
          end
          2'd1: begin
            held  <= {8'h00, sd_rd_val_data[7:0]};
            phase <= 2'd2;
            if (pix_cnt != max_q) begin
              sdram_wr_en   <= 1'b1;
              sdram_wr_data <= {held[15:11], held[7:2], sd_rd_val_data[15:11]};
              pix_cnt       <= pix_cnt + 24'd1;
            end
          end
          default: begin
            phase <= 2'd0;
            if (pix_cnt != max_q) begin
              sdram_wr_en   <= 1'b1;
              sdram_wr_data <= {held[7:3], sd_rd_val_data[15:10], sd_rd_val_data[7:3]};
              pix_cnt       <= pix_cnt + 24'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_photo_loader.sv
// Directed bench for sd_photo_loader: emulates the SD read port and checks
// requests, completion timing and every written pixel against a byte-stream model.
module tb_sd_photo_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sdram_max_addr;
  logic [15:0] sd_sec_num;
  logic        load_start, pic_sel, sd_rd_busy, sd_rd_val_en;
  logic [15:0] sd_rd_val_data;
  logic        sd_rd_start_en, sdram_wr_en, load_busy, load_done;
  logic [31:0] sd_rd_sec_addr;
  logic [15:0] sdram_wr_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] wr_q[$];
  logic [31:0] addr_q[$];
  int done_cnt = 0;

  sd_photo_loader dut (
    .clk(clk), .rst_n(rst_n), .sdram_max_addr(sdram_max_addr), .sd_sec_num(sd_sec_num),
    .load_start(load_start), .pic_sel(pic_sel), .sd_rd_busy(sd_rd_busy),
    .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
    .sd_rd_start_en(sd_rd_start_en), .sd_rd_sec_addr(sd_rd_sec_addr),
    .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data),
    .load_busy(load_busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sdram_wr_en)    wr_q.push_back(sdram_wr_data);
    if (sd_rd_start_en) addr_q.push_back(sd_rd_sec_addr);
    if (load_done)      done_cnt++;
  end

  function automatic logic [15:0] word_gen(input int i);
    logic [31:0] t;
    if (i == 0) return 16'hF8FC;
    if (i == 1) return 16'hF8FF;
    if (i == 2) return 16'h00F8;
    t = i * 32'd40503 + 32'd4660;
    return t[15:0];
  endfunction

  function automatic logic [7:0] byte_at(input int j);
    logic [15:0] w;
    w = word_gen(j / 2);
    return (j % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] pix_model(input int k);
    logic [7:0] r, g, b;
    r = byte_at(3 * k);
    g = byte_at(3 * k + 1);
    b = byte_at(3 * k + 2);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wr_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start(input logic sel, input logic [23:0] mx, input logic [15:0] sn);
    pic_sel = sel;
    sdram_max_addr = mx;
    sd_sec_num = sn;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // One sector: request seen, busy rises, 256 words, busy falls.
  task automatic serve(input int first, input bit poke, input bit more);
    int n;
    n = 0;
    while (!sd_rd_start_en && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, sd_rd_start_en}, 32'd1);
    tick();
    sd_rd_busy = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      sd_rd_val_en = 1'b1;
      sd_rd_val_data = word_gen(first + i);
      load_start = (poke && i == 10);
      pic_sel = poke;
      tick();
    end
    sd_rd_val_en = 1'b0;
    load_start = 1'b0;
    tick();
    sd_rd_busy = 1'b0;
    tick();
    if (more) check("next_req_2cyc", {31'd0, sd_rd_start_en}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (load_busy && n < 10) begin
      tick();
      n++;
    end
    check("back_to_idle", {31'd0, load_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sdram_max_addr = '0; sd_sec_num = '0; load_start = 1'b0; pic_sel = 1'b0;
    sd_rd_busy = 1'b0; sd_rd_val_en = 1'b0; sd_rd_val_data = '0;
    repeat (3) tick();
    check("rst_start_en", {31'd0, sd_rd_start_en}, 32'd0);
    check("rst_addr", sd_rd_sec_addr, 32'd0);
    check("rst_wr_en", {31'd0, sdram_wr_en}, 32'd0);
    check("rst_wr_data", {16'd0, sdram_wr_data}, 32'd0);
    check("rst_busy_done", {30'd0, load_busy, load_done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Image 0, one sector, 4 pixels; also the bit-exact packing pattern.
    clear();
    start(1'b0, 24'd4, 16'd1);
    check("t1_busy_n1", {31'd0, load_busy}, 32'd1);
    check("t1_start_n1", {31'd0, sd_rd_start_en}, 32'd1);
    check("t1_addr", sd_rd_sec_addr, 32'd8000);
    serve(0, 1'b0, 1'b0);
    check("t1_done_now", {31'd0, load_done}, 32'd1);
    tick();
    check("t1_busy_after_done", {31'd0, load_busy}, 32'd0);
    wait_idle();
    check("t1_nreq", addr_q.size(), 32'd1);
    check("t1_nwr", wr_q.size(), 32'd4);
    check("t1_ndone", done_cnt, 32'd1);
    if (wr_q.size() >= 4) begin
      check("pack_px0", {16'd0, wr_q[0]}, 32'h0000FFFF);
      check("pack_px1", {16'd0, wr_q[1]}, 32'h0000F81F);
      check("t1_px2", {16'd0, wr_q[2]}, {16'd0, pix_model(2)});
      check("t1_px3", {16'd0, wr_q[3]}, {16'd0, pix_model(3)});
    end

    // Image 1, three sectors, 256 pixels; phase carries across sectors.
    clear();
    start(1'b1, 24'd256, 16'd3);
    serve(0, 1'b0, 1'b1);
    serve(256, 1'b0, 1'b1);
    serve(512, 1'b0, 1'b0);
    wait_idle();
    check("t3_nreq", addr_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < addr_q.size(); i++)
      check("t3_addr", addr_q[i], 32'd16000 + i);
    check("t3_nwr", wr_q.size(), 32'd256);
    for (int k = 0; k < wr_q.size() && k < 256; k++)
      check("t3_px", {16'd0, wr_q[k]}, {16'd0, pix_model(k)});
    check("t3_ndone", done_cnt, 32'd1);

    // Zero sectors: no request, done two cycles after start.
    clear();
    start(1'b0, 24'd8, 16'd0);
    check("t4_busy", {31'd0, load_busy}, 32'd1);
    check("t4_no_req", {31'd0, sd_rd_start_en}, 32'd0);
    tick();
    check("t4_done", {31'd0, load_done}, 32'd1);
    tick();
    check("t4_idle", {31'd0, load_busy}, 32'd0);
    check("t4_nreq", addr_q.size(), 32'd0);
    check("t4_nwr", wr_q.size(), 32'd0);
    check("t4_ndone", done_cnt, 32'd1);

    // Mid-load input changes and a stray load_start are ignored.
    clear();
    start(1'b0, 24'd10, 16'd2);
    sdram_max_addr = 24'd3;
    sd_sec_num = 16'd5;
    serve(0, 1'b1, 1'b1);
    serve(256, 1'b0, 1'b0);
    wait_idle();
    check("t5_nreq", addr_q.size(), 32'd2);
    if (addr_q.size() >= 2) begin
      check("t5_addr0", addr_q[0], 32'd8000);
      check("t5_addr1", addr_q[1], 32'd8001);
    end
    check("t5_nwr", wr_q.size(), 32'd10);
    if (wr_q.size() >= 10) check("t5_px9", {16'd0, wr_q[9]}, {16'd0, pix_model(9)});
    check("t5_ndone", done_cnt, 32'd1);

    // Reset in WAIT_HI after 10 pixels, then a fresh load from phase 0.
    clear();
    start(1'b0, 24'd100, 16'd3);
    tick();
    for (int i = 0; i < 15; i++) begin
      sd_rd_val_en = 1'b1;
      sd_rd_val_data = word_gen(i);
      tick();
    end
    sd_rd_val_en = 1'b0;
    tick();
    check("t6_nwr_pre", wr_q.size(), 32'd10);
    check("t6_still_busy", {31'd0, load_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy_done", {30'd0, load_busy, load_done}, 32'd0);
    check("t6_rst_start", {31'd0, sd_rd_start_en}, 32'd0);
    check("t6_rst_addr", sd_rd_sec_addr, 32'd0);
    check("t6_rst_wr", {15'd0, sdram_wr_en, sdram_wr_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    clear();
    start(1'b1, 24'd2, 16'd1);
    check("t6_addr", sd_rd_sec_addr, 32'd16000);
    serve(0, 1'b0, 1'b0);
    wait_idle();
    check("t6_nwr", wr_q.size(), 32'd2);
    if (wr_q.size() >= 2) begin
      check("t6_px0", {16'd0, wr_q[0]}, {16'd0, pix_model(0)});
      check("t6_px1", {16'd0, wr_q[1]}, {16'd0, pix_model(1)});
    end
    check("t6_ndone", done_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
